// File: rtl/subtractor_pkg.sv
// Shared definitions for the subtractor family: FSM encoding and default width.
package subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned SUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } sub_state_e;

  // Bit counter width: enough to index WIDTH bits, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_ctrl_if #(
  parameter int unsigned WIDTH = subtractor_pkg::SUB_DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/full_subtractor.sv
// 1-bit full subtractor built from two half subtractors and an OR of their borrows.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs0 (.a(a),  .b(b),   .d(d1), .bout(b1));
  half_subtractor u_hs1 (.a(d1), .b(bin), .d(d),  .bout(b2));

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b: one full-subtractor cell stepped LSB first, one bit per clock.
module serial_subtractor_ctrl
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  serial_subtractor_ctrl_if.slave    bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  sub_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             brw;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             d;
  logic             bo;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .d    (d),
    .bout (bo)
  );

  // Result shifts in from the MSB; a 1-bit result is just the cell output.
  if (WIDTH == 1) begin : g_res_w1
    assign res_next = d;
  end else begin : g_res_wn
    assign res_next = {d, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      brw      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          brw    <= bo;
          cnt    <= cnt + CW'(1);
          // Last bit: publish the result and borrow together with done.
          if (cnt == CW'(WIDTH - 1)) begin
            diff_q   <= res_next;
            borrow_q <= bo;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench: vector table, corner sequences, random and exhaustive runs vs. arithmetic model.
module tb_serial_subtractor_ctrl;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  logic [7:0] last_d8;
  logic       last_b8;

  serial_subtractor_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_diff;
    logic       exp_borrow;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // busy and done must never be high together on either instance
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ((bus8.busy && bus8.done) || (bus4.busy && bus4.done)) begin
        n_err++;
        $display("FAIL busy_done_overlap: busy8=%0b done8=%0b busy4=%0b done4=%0b",
                 bus8.busy, bus8.done, bus4.busy, bus4.done);
      end
    end
  end

  // One full WIDTH=8 operation with timing, hold and result checks.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input string name);
    int         busy_n;
    int         done_n;
    int         done_k;
    logic       hold_ok;
    logic [7:0] ed;
    logic       eb;
    ed = a - b;
    eb = (a < b);
    busy_n = 0;
    done_n = 0;
    done_k = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus8.start = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
      end
      if (bus8.busy) busy_n++;
      if (bus8.done) begin
        done_n++;
        done_k = k;
      end
      if (k <= 8 && (bus8.diff !== last_d8 || bus8.borrow_out !== last_b8)) hold_ok = 1'b0;
    end
    chk({name, " busy_cycles"}, 32'(busy_n), 32'd8);
    chk({name, " done_count"}, 32'(done_n), 32'd1);
    chk({name, " done_cycle"}, 32'(done_k), 32'd9);
    chk({name, " result_hold"}, 32'(hold_ok), 32'd1);
    chk({name, " diff"}, 32'(bus8.diff), 32'(ed));
    chk({name, " borrow"}, 32'(bus8.borrow_out), 32'(eb));
    last_d8 = ed;
    last_b8 = eb;
    @(negedge clk);
    chk({name, " idle_after"}, 32'({bus8.busy, bus8.done}), 32'd0);
  endtask

  vec_t vt [7];
  int   done_seen;
  int   pat_bad;
  int   busy_n;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_cmp = 0;
    n_err = 0;
    last_d8 = 8'h00;
    last_b8 = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;

    vt[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vt[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vt[2] = '{8'hAA, 8'hAA, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vt[4] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vt[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vt[6] = '{8'h01, 8'h80, 8'h81, 1'b1};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst8 outputs", 32'({bus8.busy, bus8.done, bus8.borrow_out, bus8.diff}), 32'd0);
    chk("rst4 outputs", 32'({bus4.busy, bus4.done, bus4.borrow_out, bus4.diff}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst8 idle", 32'({bus8.busy, bus8.done, bus8.diff}), 32'd0);

    // Table vectors, each operand result checked against the hand-derived value
    for (int i = 0; i < 7; i++) begin
      op8(vt[i].a, vt[i].b, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table_diff", i), 32'(bus8.diff), 32'(vt[i].exp_diff));
      chk($sformatf("vec%0d table_borrow", i), 32'(bus8.borrow_out), 32'(vt[i].exp_borrow));
    end

    // Start held through RUN and DONE: one done, then a new op at the first IDLE edge
    done_seen = 0;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01;
    @(posedge clk);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) begin bus8.a = 8'h00; bus8.b = 8'hFF; end
      if (k == 11) bus8.start = 1'b0;
      if (k <= 10 && bus8.done) done_seen++;
      if (k == 9) begin
        chk("hold_start done", 32'(bus8.done), 32'd1);
        chk("hold_start diff", 32'(bus8.diff), 32'h0F);
        chk("hold_start borrow", 32'(bus8.borrow_out), 32'd0);
      end
      if (k == 10) chk("hold_start idle", 32'({bus8.busy, bus8.done}), 32'd0);
      if (k == 11) chk("hold_start reissue_busy", 32'(bus8.busy), 32'd1);
      if (k == 19) begin
        chk("reissue done", 32'(bus8.done), 32'd1);
        chk("reissue diff", 32'(bus8.diff), 32'h01);
        chk("reissue borrow", 32'(bus8.borrow_out), 32'd1);
      end
    end
    chk("hold_start single_done", 32'(done_seen), 32'd1);
    last_d8 = 8'h01;
    last_b8 = 1'b1;
    @(negedge clk);

    // Reset in the 4th RUN cycle aborts the operation
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus8.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort outputs", 32'({bus8.busy, bus8.done, bus8.borrow_out, bus8.diff}), 32'd0);
    last_d8 = 8'h00;
    last_b8 = 1'b0;
    done_seen = 0;
    busy_n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.done) done_seen++;
      if (bus8.busy) busy_n++;
    end
    chk("abort no_done", 32'(done_seen), 32'd0);
    chk("abort no_busy", 32'(busy_n), 32'd0);
    op8(8'h03, 8'h05, "after_abort");

    // Reset and start on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1; bus8.start = 1'b1; bus8.a = 8'h44; bus8.b = 8'h11;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus8.start = 1'b0;
    @(negedge clk);
    chk("rst_start dropped", 32'({bus8.busy, bus8.done, bus8.diff}), 32'd0);
    last_d8 = 8'h00;
    last_b8 = 1'b0;

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) op8(8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));

    // Exhaustive WIDTH=4 at the maximum issue rate, start held high throughout
    done_seen = 0;
    pat_bad = 0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'h0; bus4.b = 4'h0;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] ea;
      logic [3:0] eb4;
      logic [3:0] ed4;
      logic       ebr;
      ea  = 4'(i >> 4);
      eb4 = 4'(i);
      ed4 = ea - eb4;
      ebr = (ea < eb4);
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (bus4.done) done_seen++;
        if (k <= 4 && !(bus4.busy && !bus4.done)) pat_bad++;
        if (k == 5) begin
          if (!(bus4.done && !bus4.busy)) pat_bad++;
          chk($sformatf("exh a=%0h b=%0h", ea, eb4), 32'({bus4.borrow_out, bus4.diff}),
              32'({ebr, ed4}));
          if (i == 255) bus4.start = 1'b0;
          else begin
            bus4.a = 4'((i + 1) >> 4);
            bus4.b = 4'(i + 1);
          end
        end
      end
      @(posedge clk);
      @(negedge clk);
      if (bus4.busy || bus4.done) pat_bad++;
    end
    repeat (8) begin
      @(negedge clk);
      if (bus4.done) done_seen++;
    end
    chk("exh done_count", 32'(done_seen), 32'd256);
    chk("exh timing_pattern", 32'(pat_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
